rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares one synchronous single-port ROM between two requesters: the instruction-fetch port (I) and the data-load port (D).
- The ROM has a fixed 1-cycle read latency: address sampled on a clk edge, data valid after that edge.
- The block does round-robin arbitration and issues the winning address to the ROM.
- It steers the returned word to the correct requester and holds responses when a requester back-pressures.

Parameters:
- ADDRESS_WIDTH, 14, ROM word-address width.
- DATA_WIDTH, 32, ROM word width.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  I-port read request.
- i_req_addr  in  ADDRESS_WIDTH  I-port word address.
- i_req_ready  out  1  I-port request accepted this cycle.
- i_rsp_valid  out  1  I-port read data valid.
- i_rsp_data  out  DATA_WIDTH  I-port read data.
- i_rsp_ready  in  1  I-port consumes response.
- d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_ready: same as the I-port signals, for the D port.
- rom_addr  out  ADDRESS_WIDTH  address to ROM (ROM registers it).
- rom_q  in  DATA_WIDTH  ROM data, valid one cycle after address sampled.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Handshakes: request accepted when x_req_valid & x_req_ready on a rising edge. Response consumed when x_rsp_valid & x_rsp_ready.
- Per-port state: outstanding flag out_x, set on accept and cleared on response consume. Also a hold register hold_x[DATA_WIDTH-1:0] and a flag held_x.
- Eligibility: eligible_x = x_req_valid & (!out_x | (x_rsp_valid & x_rsp_ready)). Back-to-back accepts at full rate are possible when rsp_ready is held high.
- Arbitration: round-robin pointer last (I or D), reset to D so I wins the first contention.
  - Both eligible: grant the port != last.
  - One eligible: grant it.
  - On every accept, last <= granted port.
- x_req_ready = granted_x. It is combinational from req_valid/state (ready may depend on valid); requesters must not depend combinationally on ready.
- At most one accept per cycle.
- rom_addr:
  - Accept cycle: granted port's address, combinational.
  - Otherwise: held at the last accepted address, from register addr_q (reset 0).
- Response timing:
  - Cycle after accept (N+1): x_rsp_valid=1 and x_rsp_data=rom_q.
  - If x_rsp_ready=0 in N+1: hold_x <= rom_q and held_x <= 1.
  - While held: x_rsp_data=hold_x (stable) and x_rsp_valid stays 1 until consumed.
  - x_rsp_valid is registered: an issued_x flag from the accept cycle, OR held_x.
- Ordering: per port, responses are in acceptance order. Only one outstanding per port, so no reordering is possible.
- Data when invalid: x_rsp_data equals rom_q when x_rsp_valid=0; no requirement on its value.
- Simultaneous events: on the same edge, a response consume and a new accept on the same port are both legal. The out flag stays 1 and the new response appears the next cycle.
- Reset values:
  - i/d_rsp_valid=0, out_x=0, held_x=0, hold_x=0, addr_q=0, last=D.
  - i/d_req_ready forced 0 while rst_n=0.
- Reset mid-operation: in-flight and held responses are discarded immediately (rsp_valid drops asynchronously). After release, behaviour is identical to a fresh power-up.
- No address range checking: out-of-range behaviour is defined by the ROM.

Test Plan:
1. ROM[0x0010]=0x00000013; I requests 0x0010, i_rsp_ready=1 -> i_req_ready=1 same cycle, rom_addr=0x0010, i_rsp_valid=1 for exactly one cycle next cycle with 0x00000013; D outputs idle.
2. I streams addr 0..7 back-to-back, ROM[k]=0xA000_000k, rsp_ready=1 -> 8 accepts in 8 consecutive cycles, responses in order 0xA0000000..0xA0000007, each one cycle after its accept.
3. I and D both valid continuously from reset, rsp_ready=1 -> grants I,D,I,D,...; each port gets one response every 2 cycles; a port is never granted twice in a row while the other is eligible.
4. D accepted at 0x0020 (ROM=0xDEADBEEF), d_rsp_ready=0 for 3 cycles -> d_rsp_valid=1 with 0xDEADBEEF stable for 4 cycles; d_req_ready=0 throughout; I keeps 1 accept/cycle; data consumed on the 4th cycle; D re-grantable that same cycle.
5. Accept I, then assert rst_n=0 in the response cycle -> i_rsp_valid drops to 0 immediately. After release with both ports valid, the first grant goes to I.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM between I and D ports.
// Steers returned words to the winner and holds them under back-pressure.
module rom_arbiter #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  output logic                     i_req_ready,
  output logic                     i_rsp_valid,
  output logic [DATA_WIDTH-1:0]    i_rsp_data,
  input  logic                     i_rsp_ready,
  input  logic                     d_req_valid,
  input  logic [ADDRESS_WIDTH-1:0] d_req_addr,
  output logic                     d_req_ready,
  output logic                     d_rsp_valid,
  output logic [DATA_WIDTH-1:0]    d_rsp_data,
  input  logic                     d_rsp_ready,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_q
);

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  port_e                    last_q, last_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

  logic                  i_issued_q, i_issued_d;
  logic                  i_held_q, i_held_d;
  logic [DATA_WIDTH-1:0] i_hold_q, i_hold_d;
  logic                  d_issued_q, d_issued_d;
  logic                  d_held_q, d_held_d;
  logic [DATA_WIDTH-1:0] d_hold_q, d_hold_d;

  logic i_out, d_out;
  logic i_elig, d_elig;
  logic gnt_i, gnt_d;

  // Eligibility and round-robin grant; the port that lost last time wins ties.
  always_comb begin
    i_out  = i_issued_q | i_held_q;
    d_out  = d_issued_q | d_held_q;
    i_elig = i_req_valid & (!i_out | i_rsp_ready);
    d_elig = d_req_valid & (!d_out | d_rsp_ready);
    gnt_i  = rst_n & i_elig & (!d_elig | (last_q == PORT_D));
    gnt_d  = rst_n & d_elig & (!i_elig | (last_q == PORT_I));
  end

  // Address mux: winner's address on accept, else the last accepted one.
  always_comb begin
    last_d = last_q;
    addr_d = addr_q;
    unique case (1'b1)
      gnt_i: begin
        last_d = PORT_I;
        addr_d = i_req_addr;
      end
      gnt_d: begin
        last_d = PORT_D;
        addr_d = d_req_addr;
      end
      default: ;
    endcase
    rom_addr    = addr_d;
    i_req_ready = gnt_i;
    d_req_ready = gnt_d;
  end

  // Per-port response tracking: capture ROM word if not taken on arrival.
  always_comb begin
    i_issued_d = gnt_i;
    i_held_d   = i_held_q;
    i_hold_d   = i_hold_q;
    if (i_out && i_rsp_ready) i_held_d = 1'b0;
    if (i_issued_q && !i_rsp_ready) begin
      i_held_d = 1'b1;
      i_hold_d = rom_q;
    end
    d_issued_d = gnt_d;
    d_held_d   = d_held_q;
    d_hold_d   = d_hold_q;
    if (d_out && d_rsp_ready) d_held_d = 1'b0;
    if (d_issued_q && !d_rsp_ready) begin
      d_held_d = 1'b1;
      d_hold_d = rom_q;
    end
  end

  // Response outputs: held word takes priority over the live ROM output.
  always_comb begin
    i_rsp_valid = i_out;
    d_rsp_valid = d_out;
    i_rsp_data  = i_held_q ? i_hold_q : rom_q;
    d_rsp_data  = d_held_q ? d_hold_q : rom_q;
  end

  // State registers; reset discards all in-flight and held responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= PORT_D;
      addr_q     <= '0;
      i_issued_q <= 1'b0;
      i_held_q   <= 1'b0;
      i_hold_q   <= '0;
      d_issued_q <= 1'b0;
      d_held_q   <= 1'b0;
      d_hold_q   <= '0;
    end else begin
      last_q     <= last_d;
      addr_q     <= addr_d;
      i_issued_q <= i_issued_d;
      i_held_q   <= i_held_d;
      i_hold_q   <= i_hold_d;
      d_issued_q <= d_issued_d;
      d_held_q   <= d_held_d;
      d_hold_q   <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed steps with expected grants, plus a
// monitor that checks each response against a queue of expected words.
module tb_rom_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_req_ready;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          i_rsp_ready = 1'b1;
  logic          d_req_valid = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic          d_req_ready;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          d_rsp_ready = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] iq[$];
  logic [DW-1:0] dq[$];

  rom_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_req_ready(i_req_ready), .i_rsp_valid(i_rsp_valid),
    .i_rsp_data(i_rsp_data), .i_rsp_ready(i_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data), .d_rsp_ready(d_rsp_ready),
    .rom_addr(rom_addr), .rom_q(rom_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    if (a == 14'h0010) r = 32'h0000_0013;
    else if (a == 14'h0020) r = 32'hDEAD_BEEF;
    else if (a < 14'd8) r = 32'hA000_0000 | 32'(a);
    else r = 32'hC0DE_0000 | 32'(a);
    return r;
  endfunction

  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_rsp_valid) begin
        if (iq.size() == 0) chk("i_rsp_unexpected", 32'(i_rsp_valid), 32'd0);
        else begin
          chk("i_rsp_data", i_rsp_data, iq[0]);
          if (i_rsp_ready) void'(iq.pop_front());
        end
      end
      if (d_rsp_valid) begin
        if (dq.size() == 0) chk("d_rsp_unexpected", 32'(d_rsp_valid), 32'd0);
        else begin
          chk("d_rsp_data", d_rsp_data, dq[0]);
          if (d_rsp_ready) void'(dq.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic iv, input logic [AW-1:0] ia,
                      input logic dv, input logic [AW-1:0] da,
                      input logic irr, input logic drr,
                      input logic ei, input logic ed);
    i_req_valid = iv;
    i_req_addr  = ia;
    d_req_valid = dv;
    d_req_addr  = da;
    i_rsp_ready = irr;
    d_rsp_ready = drr;
    @(negedge clk);
    chk("i_req_ready", 32'(i_req_ready), 32'(ei));
    chk("d_req_ready", 32'(d_req_ready), 32'(ed));
    if (ei) chk("rom_addr_i", 32'(rom_addr), 32'(ia));
    if (ed) chk("rom_addr_d", 32'(rom_addr), 32'(da));
    if (i_req_valid && i_req_ready) iq.push_back(rom_fn(ia));
    if (d_req_valid && d_req_ready) dq.push_back(rom_fn(da));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    rst_n = 1'b0;
    iq.delete();
    dq.delete();
    #1;
    chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_i_req_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_req_ready", 32'(d_req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single I fetch, one-cycle response, D idle
    step(1'b1, 14'h0010, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    idle();

    // I streams 0..7 at full rate
    for (int k = 0; k < 8; k++)
      step(1'b1, AW'(k), 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // Both ports continuously valid from reset: I,D,I,D,...
    do_reset();
    for (int k = 0; k < 6; k++)
      step(1'b1, AW'(14'h100 + k), 1'b1, AW'(14'h200 + k), 1'b1, 1'b1,
           (k % 2) == 0, (k % 2) == 1);
    idle();

    // D held under back-pressure while I streams
    step(1'b0, '0, 1'b1, 14'h0020, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      step(1'b1, AW'(14'h30 + k), 1'b1, 14'h0021, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 14'h0033, 1'b1, 14'h0021, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 14'h0034, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // Reset during the response cycle, then fresh arbitration
    do_reset();
    step(1'b1, 14'h0040, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    i_req_valid = 1'b0;
    chk("pre_rst_i_rsp_valid", 32'(i_rsp_valid), 32'd1);
    do_reset();
    step(1'b1, 14'h0050, 1'b1, 14'h0060, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 14'h0051, 1'b1, 14'h0060, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    idle();

    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
